// File: rtl/wb_retire_monitor.sv
// Writeback-stage observer: shadow integer/FP register files, retire counters and a
// timestamped show-ahead event FIFO. Define WB_MON_FP_EN to build the FP shadow/capture path.
module wb_retire_monitor #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteWFinal,
  input  logic             RegFWriteWFinal,
  input  logic [4:0]       RdW,
  input  logic [31:0]      ResultW,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] ev_ts,
  output logic [4:0]       ev_rd,
  output logic [31:0]      ev_data,
  output logic             ev_fp,
  output logic             ev_both,
  input  logic [4:0]       q_addr,
  output logic [31:0]      q_int,
  output logic [31:0]      q_fp,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] cntOne = 1;
  localparam logic [AW:0]      ptrOne = 1;

  typedef struct packed {
    logic [CNT_W-1:0] ts;
    logic [4:0]       rd;
    logic [31:0]      data;
    logic             fp;
    logic             both;
  } eventT;

  logic             cap;
  logic             capFp;
  eventT            newEvent;
  eventT            headEvent;
  eventT            evMem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;
  logic [CNT_W-1:0] cycleCnt;
  logic [31:0]      intRegs [32];

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
`ifdef WB_MON_FP_EN
    capFp = RegFWriteWFinal & ~RegWriteWFinal;
`else
    capFp = 1'b0;
`endif
    cap      = RegWriteWFinal | capFp;
    newEvent = '{ts:   cycleCnt,
                 rd:   RdW,
                 data: ResultW,
                 fp:   capFp,
                 both: RegWriteWFinal & RegFWriteWFinal};
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign pop   = ~empty & ev_ready;
  assign push  = cap & (~full | pop);
  assign drop  = cap & full & ~pop;

  // NOTE: the FIFO storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      evMem[wrPtr[AW-1:0]] <= newEvent;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      cycleCnt   <= '0;
      retire_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      cycleCnt <= cycleCnt + cntOne;
      if (push) begin
        wrPtr <= wrPtr + ptrOne;
      end
      if (pop) begin
        rdPtr <= rdPtr + ptrOne;
      end
      if (cap) begin
        retire_cnt <= retire_cnt + cntOne;
      end
      if (drop) begin
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + cntOne;
        end
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    headEvent = evMem[rdPtr[AW-1:0]];
    if (empty) begin
      headEvent = '0;
    end
  end

  assign ev_valid = ~empty;
  assign ev_ts    = headEvent.ts;
  assign ev_rd    = headEvent.rd;
  assign ev_data  = headEvent.data;
  assign ev_fp    = headEvent.fp;
  assign ev_both  = headEvent.both;

  // Shadow files are architectural state, so unlike the FIFO storage they clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        intRegs[i] <= '0;
      end
    end else if (RegWriteWFinal && (RdW != 5'd0)) begin
      intRegs[RdW] <= ResultW;
    end
  end

  assign q_int = (q_addr == 5'd0) ? 32'd0 : intRegs[q_addr];

`ifdef WB_MON_FP_EN
  logic [31:0] fpRegs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        fpRegs[i] <= '0;
      end
    end else if (RegFWriteWFinal) begin
      fpRegs[RdW] <= ResultW;
    end
  end

  assign q_fp = fpRegs[q_addr];
`else
  assign q_fp = '0;
`endif

endmodule

// File: tb/tb_wb_retire_monitor.sv
// Scoreboard bench for wb_retire_monitor: directed plan items plus randomized traffic
// against a queue-based reference model; a negedge monitor compares DUT outputs.
module tb_wb_retire_monitor;
  localparam int DEPTH = 16;
  localparam int CNT_W = 32;
`ifdef WB_MON_FP_EN
  localparam bit fpEn = 1'b1;
`else
  localparam bit fpEn = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             RegWriteWFinal;
  logic             RegFWriteWFinal;
  logic [4:0]       RdW;
  logic [31:0]      ResultW;
  logic             ev_valid;
  logic             ev_ready;
  logic [CNT_W-1:0] ev_ts;
  logic [4:0]       ev_rd;
  logic [31:0]      ev_data;
  logic             ev_fp;
  logic             ev_both;
  logic [4:0]       q_addr;
  logic [31:0]      q_int;
  logic [31:0]      q_fp;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow;

  wb_retire_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RegWriteWFinal(RegWriteWFinal), .RegFWriteWFinal(RegFWriteWFinal),
    .RdW(RdW), .ResultW(ResultW),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ts(ev_ts), .ev_rd(ev_rd),
    .ev_data(ev_data), .ev_fp(ev_fp), .ev_both(ev_both),
    .q_addr(q_addr), .q_int(q_int), .q_fp(q_fp),
    .retire_cnt(retire_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ts;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        fp;
    logic        both;
  } expEventT;

  expEventT    sbQ[$];
  int          nChecks = 0;
  int          nErrors = 0;
  bit          monOn = 1'b0;

  // Reference model state, always describing the DUT as of the most recent edge.
  int          occ;
  logic [31:0] mCycle;
  logic [31:0] mRetire;
  logic [31:0] mDrop;
  logic        mOverflow;
  logic [31:0] mInt [32];
  logic [31:0] mFp  [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelClear();
    occ       = 0;
    mCycle    = '0;
    mRetire   = '0;
    mDrop     = '0;
    mOverflow = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mInt[i] = '0;
      mFp[i]  = '0;
    end
    sbQ.delete();
  endtask

  // Drives one cycle of stimulus (called just after an edge), queues the expected event,
  // waits for the edge and then advances the model.
  task automatic step(input logic rw, input logic fw, input logic [4:0] rd,
                      input logic [31:0] res, input logic rdy, input logic rst = 1'b0);
    logic capNow, popNow, pushNow;
    RegWriteWFinal  = rw;
    RegFWriteWFinal = fw;
    RdW             = rd;
    ResultW         = res;
    ev_ready        = rdy;
    reset           = rst;
    q_addr          = 5'($urandom_range(0, 31));
    capNow  = rw | (fw & fpEn);
    popNow  = (occ > 0) && rdy;
    pushNow = !rst && capNow && ((occ < DEPTH) || popNow);
    if (pushNow) begin
      sbQ.push_back('{ts: mCycle, rd: rd, data: res, fp: fpEn & fw & ~rw, both: rw & fw});
    end
    @(posedge clk);
    #1;
    if (rst) begin
      modelClear();
    end else begin
      mCycle = mCycle + 1;
      if (capNow) begin
        mRetire = mRetire + 1;
        if (!pushNow) begin
          if (mDrop != 32'hFFFF_FFFF) mDrop = mDrop + 1;
          mOverflow = 1'b1;
        end
      end
      occ = occ + (pushNow ? 1 : 0) - (popNow ? 1 : 0);
      if (rw && rd != 5'd0) mInt[rd] = res;
      if (fw && fpEn) mFp[rd] = res;
    end
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, rdy);
  endtask

  // Monitor: compares the presented head with the scoreboard and the counters with the model.
  always @(negedge clk) begin
    if (monOn) begin
      check("ev_valid", ev_valid, occ > 0);
      if (ev_valid && occ > 0 && sbQ.size() > 0) begin
        check("ev_ts", ev_ts, sbQ[0].ts);
        check("ev_rd", ev_rd, sbQ[0].rd);
        check("ev_data", ev_data, sbQ[0].data);
        check("ev_fp", ev_fp, sbQ[0].fp);
        check("ev_both", ev_both, sbQ[0].both);
        if (ev_ready) void'(sbQ.pop_front());
      end
      check("q_int", q_int, (q_addr == 5'd0) ? 32'd0 : mInt[q_addr]);
      check("q_fp", q_fp, fpEn ? mFp[q_addr] : 32'd0);
      check("retire_cnt", retire_cnt, mRetire);
      check("drop_cnt", drop_cnt, mDrop);
      check("overflow", overflow, mOverflow);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] retireBefore;
    RegWriteWFinal  = 1'b0;
    RegFWriteWFinal = 1'b0;
    RdW             = '0;
    ResultW         = '0;
    ev_ready        = 1'b0;
    q_addr          = '0;
    reset           = 1'b1;
    modelClear();

    // Reset state
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    monOn = 1'b1;
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_ts", ev_ts, 0);
    check("rst_ev_rd", ev_rd, 0);
    check("rst_ev_data", ev_data, 0);
    check("rst_retire", retire_cnt, 0);
    check("rst_overflow", overflow, 0);

    // Single integer write to x5
    step(1'b1, 1'b0, 5'd5, 32'h0000_00AA, 1'b0);
    check("w5_valid", ev_valid, 1);
    check("w5_rd", ev_rd, 5);
    check("w5_data", ev_data, 32'hAA);
    check("w5_fp", ev_fp, 0);
    check("w5_retire", retire_cnt, 1);
    q_addr = 5'd5;
    #1 check("w5_q_int", q_int, 32'hAA);

    // Integer write to x0: shadow stays 0, event still logged with raw data
    step(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    q_addr = 5'd0;
    #1 check("x0_q_int", q_int, 0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    check("x0_ev_rd", ev_rd, 0);
    check("x0_ev_data", ev_data, 32'hFFFF_FFFF);
    idle(1'b1, 2);

    // FP-only write to f0
    retireBefore = retire_cnt;
    step(1'b0, 1'b1, 5'd0, 32'h3F80_0000, 1'b0);
    check("fp_valid", ev_valid, fpEn);
    check("fp_ev_fp", ev_fp, fpEn);
    check("fp_retire", retire_cnt, retireBefore + 32'(fpEn));
    q_addr = 5'd0;
    #1 check("fp_q_fp", q_fp, fpEn ? 32'h3F80_0000 : 32'd0);
    idle(1'b1, 2);

    // Overfill: 18 writes with the consumer stalled
    retireBefore = retire_cnt;
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b0, 5'(1 + (i % 31)), $urandom, 1'b0);
    end
    check("ovf_drop", drop_cnt, 2);
    check("ovf_flag", overflow, 1);
    check("ovf_retire", retire_cnt, retireBefore + 18);

    // Full with simultaneous push and pop: no drop; a following stalled write drops
    step(1'b1, 1'b0, 5'd7, 32'h0000_CAFE, 1'b1);
    check("fullpp_drop", drop_cnt, 2);
    step(1'b1, 1'b0, 5'd8, 32'h0000_BEEF, 1'b0);
    check("still_full_drop", drop_cnt, 3);
    idle(1'b1, DEPTH + 2);
    check("drain_empty", ev_valid, 0);
    check("drain_sb_empty", sbQ.size(), 0);

    // Both strobes high
    retireBefore = retire_cnt;
    step(1'b1, 1'b1, 5'd3, 32'h0000_1234, 1'b0);
    check("both_ev_both", ev_both, 1);
    check("both_ev_fp", ev_fp, 0);
    check("both_retire", retire_cnt, retireBefore + 1);
    q_addr = 5'd3;
    #1;
    check("both_q_int", q_int, 32'h1234);
    check("both_q_fp", q_fp, fpEn ? 32'h1234 : 32'd0);

    // Reset in the middle of a drain
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'(10 + i), $urandom, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    check("mid_rst_valid", ev_valid, 0);
    check("mid_rst_retire", retire_cnt, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_overflow", overflow, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom, 1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 249) == 0));
    end
    idle(1'b1, DEPTH + 4);
    check("final_empty", ev_valid, 0);
    check("final_sb_empty", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule

// File: doc/wb_retire_monitor.md
Name: wb_retire_monitor

Overview:
- Observation block on the writeback stage of the RV32IMF pipeline; consumes the final integer/FP write-enables, destination register and result each cycle.
- Keeps shadow integer and FP register files, retire counters and a timestamped event FIFO drained over a valid/ready port.
- Lets benches and debug logic read architectural state and retire order without probing core internals.

Parameters:
- DEPTH, 16, event FIFO entries; power of two, minimum 2.
- CNT_W, 32, width of the cycle, retire and drop counters.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- RegWriteWFinal  input  1  integer register-file write strobe from writeback.
- RegFWriteWFinal  input  1  FP register-file write strobe from writeback.
- RdW  input  5  writeback destination register.
- ResultW  input  32  writeback result.
- ev_valid  output  1  FIFO head holds an event.
- ev_ready  input  1  consumer accepts the head event.
- ev_ts  output  CNT_W  cycle stamp of the head event.
- ev_rd  output  5  destination register of the head event.
- ev_data  output  32  result of the head event.
- ev_fp  output  1  head event is an FP write.
- ev_both  output  1  head event had both strobes high.
- q_addr  input  5  shadow query index.
- q_int  output  32  shadow integer register[q_addr].
- q_fp  output  32  shadow FP register[q_addr].
- retire_cnt  output  CNT_W  total captured events.
- drop_cnt  output  CNT_W  events lost to a full FIFO.
- overflow  output  1  sticky: at least one drop since reset.

Behaviour:
- Reset (sync, active-high): FIFO empty, ev_valid=0, ev_* = 0, shadow arrays all 0, all counters 0, overflow=0, cycle counter 0. Reset has priority over every other event in the same cycle; a reset mid-drain discards all FIFO contents.
- Cycle counter: increments by 1 every non-reset cycle and wraps modulo 2^CNT_W. An event captured on edge N is stamped with the counter value before that edge.
- Capture condition: cap = RegWriteWFinal | RegFWriteWFinal, sampled on the rising edge.
- On cap, retire_cnt increments by 1 and wraps.
- Shadow integer file: updated when RegWriteWFinal is high and RdW != 0. Entry x0 always reads 0.
- Shadow FP file: updated when RegFWriteWFinal is high, including f0.
- Both strobes high: both shadow files update; one FIFO entry is logged with ev_fp=0, ev_both=1.
- Logged event fields:
  - ev_fp = RegFWriteWFinal & ~RegWriteWFinal.
  - An integer write to x0 is logged with ev_rd=0 and the raw ResultW.
- Shadow query: combinational read of the registered arrays, no write bypass; a same-cycle query returns the pre-write value.
- FIFO:
  - Show-ahead: head fields are driven from storage combinationally.
  - Latency: an event captured on edge N appears on ev_valid after edge N when the FIFO was empty.
  - Pop when ev_valid & ev_ready.
  - Push when cap and (not full, or pop in the same cycle).
  - Full with no pop: the event is dropped. drop_cnt increments and saturates at all-ones. overflow is set and held until reset. Shadow files and retire_cnt still update.
  - Full with push and pop in the same cycle: both succeed; occupancy is unchanged.
  - Empty with push and pop in the same cycle: pop is ignored (ev_valid=0) and the push succeeds.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and low bits are equal.
- Handshake: while ev_valid=1 and ev_ready=0, all ev_* outputs hold stable. ev_ready while empty has no effect.

Optional Feature:
- Macro WB_MON_FP_EN.
- Defined: FP shadow file present; FP-only writes are captured, logged and counted as described above.
- Undefined:
  - FP shadow file is not built and q_fp is tied to 0.
  - RegFWriteWFinal alone does not assert cap.
  - With both strobes high, the event is logged as integer with ev_both=1.
  - ev_fp is tied to 0.

Test Plan:
- Reset, then RegWriteWFinal=1, RdW=5, ResultW=0x0000_00AA on one cycle, ev_ready=0 → next cycle ev_valid=1, ev_rd=5, ev_data=0xAA, ev_fp=0, retire_cnt=1, and q_addr=5 gives q_int=0xAA.
- Integer write RdW=0, ResultW=0xFFFF_FFFF → q_int[0]=0, one event logged with ev_rd=0 and ev_data=0xFFFF_FFFF.
- With WB_MON_FP_EN defined: RegFWriteWFinal=1, RdW=0, ResultW=0x3F80_0000 → q_fp[0]=0x3F80_0000, ev_fp=1. Same stimulus with the macro undefined → ev_valid stays 0 and retire_cnt=0.
- DEPTH=16, ev_ready=0, 18 consecutive integer writes → 16 entries held, drop_cnt=2, overflow=1, retire_cnt=18. Then assert ev_ready=1 → the first 16 events drain in order with strictly increasing ev_ts.
- FIFO full, ev_ready=1 and a new write in the same cycle → no drop, occupancy stays 16, and the new event reaches the tail.
- Both strobes high, RdW=3, ResultW=0x1234 → q_int[3]=0x1234, q_fp[3]=0x1234 (macro defined), a single event with ev_both=1, retire_cnt incremented by 1. Assert reset mid-drain → ev_valid=0 and all counters 0 on the next cycle.
